// File: rtl/ltc2203_pkg.sv
// Shared constants, FSM encoding and the channel search helper for the LTC2203 frame packer.
package ltc2203_pkg;

    localparam int N_CH   = 16;
    localparam int DW     = 16;
    localparam int CH_W   = $clog2(N_CH);
    localparam int DROP_W = 16;

    localparam logic [DW-1:0] SYNC_WORD = 16'hEB90;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_CNT  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty (caller qualifies with |mask).
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k]) idx = CH_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ltc2203_snap_buf.sv
// Snapshot storage for the frame packer: the active buffer being framed, a single pending
// slot, the saturating drop counter and the next-enabled-channel search for DATA words.
module ltc2203_snap_buf
    import ltc2203_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [N_CH*DW-1:0] sample_data,
    input  logic [N_CH-1:0]    ch_enable,
    input  logic               idle,
    input  logic               frame_done,
    input  logic               word_done,
    output logic [DW-1:0]      cur_word,
    output logic               rem_any,
    output logic               rem_last,
    output logic               pending_full,
    output logic [DROP_W-1:0]  drop_count
);

    logic [N_CH*DW-1:0] act_data;
    logic [N_CH*DW-1:0] pend_data;
    logic [N_CH-1:0]    pend_en;
    logic [N_CH-1:0]    rem_mask;
    logic [CH_W-1:0]    cur_ch;
    logic               use_pending;
    logic               load_active;
    logic               load_pending;
    logic               drop;

    // Decide where a strobe lands: active buffer, pending slot, or dropped.
    always_comb begin
        // NOTE: every signal gets a value before any condition, so no path can infer a latch.
        use_pending  = 1'b0;
        load_active  = 1'b0;
        load_pending = 1'b0;
        drop         = 1'b0;

        use_pending  = frame_done & pending_full;
        load_active  = (idle & sample_valid) | (frame_done & (pending_full | sample_valid));
        // On the closing transfer a strobe only needs the pending slot if the slot is
        // being emptied into the active buffer; otherwise it goes straight to active.
        load_pending = sample_valid & (use_pending | (~idle & ~frame_done & ~pending_full));
        drop         = sample_valid & ~idle & ~frame_done & pending_full;
    end

    // Snapshot payload registers; they are only read after being loaded.
    // NOTE: payload flops carry no reset -- control state alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (load_pending) begin
            pend_data <= sample_data;
            pend_en   <= ch_enable;
        end
        if (load_active) begin
            act_data <= use_pending ? pend_data : sample_data;
        end
    end

    // Pending-slot occupancy and the remaining-channel mask of the active frame.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pending_full <= 1'b0;
            rem_mask     <= '0;
        end else begin
            if (load_pending) begin
                pending_full <= 1'b1;
            end else if (use_pending) begin
                pending_full <= 1'b0;
            end

            if (load_active) begin
                rem_mask <= use_pending ? pend_en : ch_enable;
            end else if (word_done) begin
                rem_mask[cur_ch] <= 1'b0;
            end
        end
    end

    // Saturating count of snapshots that found both buffers occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    assign cur_ch   = lowest_set(rem_mask);
    assign cur_word = act_data[cur_ch*DW +: DW];
    assign rem_any  = |rem_mask;
    assign rem_last = rem_any && ((rem_mask & (rem_mask - N_CH'(1))) == '0);

endmodule

// File: rtl/ltc2203_frame_packer.sv
// Frames 16-channel LTC2203 snapshots into a valid/ready word stream:
// sync word, frame count, enabled channel words, XOR checksum.
module ltc2203_frame_packer
    import ltc2203_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_n,
    input  logic               SAMPLE_VALID,
    input  logic [N_CH*DW-1:0] SAMPLE_DATA,
    input  logic [N_CH-1:0]    CH_ENABLE,
    output logic [DW-1:0]      OUT_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               OUT_SOF,
    output logic               OUT_EOF,
    output logic               BUSY,
    output logic [DROP_W-1:0]  DROP_COUNT
);

    state_t          state;
    state_t          next_state;
    logic [DW-1:0]   frame_cnt;
    logic [DW-1:0]   csum;
    logic [DW-1:0]   cur_word;
    logic            rem_any;
    logic            rem_last;
    logic            pending_full;
    logic            idle;
    logic            frame_done;
    logic            word_done;
    logic            cnt_done;

    assign idle       = (state == ST_IDLE);
    assign cnt_done   = (state == ST_CNT)  & OUT_READY;
    assign word_done  = (state == ST_DATA) & OUT_READY;
    assign frame_done = (state == ST_CSUM) & OUT_READY;

    ltc2203_snap_buf u_snap (
        .clk          (CLK),
        .rst_n        (RESET_n),
        .sample_valid (SAMPLE_VALID),
        .sample_data  (SAMPLE_DATA),
        .ch_enable    (CH_ENABLE),
        .idle         (idle),
        .frame_done   (frame_done),
        .word_done    (word_done),
        .cur_word     (cur_word),
        .rem_any      (rem_any),
        .rem_last     (rem_last),
        .pending_full (pending_full),
        .drop_count   (DROP_COUNT)
    );

    // Frame sequencer state register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and stream outputs decoded from registered state; a state only moves on a transfer.
    always_comb begin
        next_state = state;
        OUT_VALID  = 1'b0;
        OUT_DATA   = '0;
        OUT_SOF    = 1'b0;
        OUT_EOF    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (SAMPLE_VALID) next_state = ST_SYNC;
            end
            ST_SYNC: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = SYNC_WORD;
                OUT_SOF   = 1'b1;
                if (OUT_READY) next_state = ST_CNT;
            end
            ST_CNT: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = frame_cnt;
                if (OUT_READY) next_state = rem_any ? ST_DATA : ST_CSUM;
            end
            ST_DATA: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = cur_word;
                if (OUT_READY && rem_last) next_state = ST_CSUM;
            end
            ST_CSUM: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = csum;
                OUT_EOF   = 1'b1;
                // A waiting or simultaneous snapshot starts the next frame with no gap.
                if (OUT_READY) next_state = (pending_full || SAMPLE_VALID) ? ST_SYNC : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Running XOR seeded with the count word, and the per-frame counter.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            csum      <= '0;
            frame_cnt <= '0;
        end else begin
            if (cnt_done) begin
                csum <= frame_cnt;
            end else if (word_done) begin
                csum <= csum ^ cur_word;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + DW'(1);
            end
        end
    end

    assign BUSY = ~idle | pending_full;

endmodule

// File: tb/tb_ltc2203_frame_packer.sv
// Scoreboard bench for ltc2203_frame_packer: stimulus pushes expected words,
// a negedge monitor pops and compares on every transfer and checks stall stability.
module tb_ltc2203_frame_packer;
    import ltc2203_pkg::*;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [15:0] data;
    } word_t;

    logic           CLK = 1'b0;
    logic           RESET_n = 1'b0;
    logic           SAMPLE_VALID = 1'b0;
    logic [255:0]   SAMPLE_DATA = '0;
    logic [15:0]    CH_ENABLE = '0;
    logic [15:0]    OUT_DATA;
    logic           OUT_VALID;
    logic           OUT_READY = 1'b0;
    logic           OUT_SOF;
    logic           OUT_EOF;
    logic           BUSY;
    logic [15:0]    DROP_COUNT;

    word_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b1;

    ltc2203_frame_packer dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_DATA  (SAMPLE_DATA),
        .CH_ENABLE    (CH_ENABLE),
        .OUT_DATA     (OUT_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_SOF      (OUT_SOF),
        .OUT_EOF      (OUT_EOF),
        .BUSY         (BUSY),
        .DROP_COUNT   (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] ramp(input logic [15:0] base);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[k*16 +: 16] = base + 16'(k);
        return d;
    endfunction

    task automatic push_frame(input logic [15:0] cnt, input logic [15:0] en,
                              input logic [255:0] d, input logic [15:0] csum);
        word_t w;
        w = '{sof: 1'b1, eof: 1'b0, data: 16'hEB90};
        exp_q.push_back(w);
        w = '{sof: 1'b0, eof: 1'b0, data: cnt};
        exp_q.push_back(w);
        for (int k = 0; k < 16; k++) begin
            if (en[k]) begin
                w = '{sof: 1'b0, eof: 1'b0, data: d[k*16 +: 16]};
                exp_q.push_back(w);
            end
        end
        w = '{sof: 1'b0, eof: 1'b1, data: csum};
        exp_q.push_back(w);
    endtask

    // Present one snapshot for exactly one cycle.
    task automatic strobe_cycle(input logic [255:0] d, input logic [15:0] en);
        SAMPLE_VALID = 1'b1;
        SAMPLE_DATA  = d;
        CH_ENABLE    = en;
        tick();
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every transfer against the scoreboard and hold words stable across stalls.
    word_t prev_word;
    bit    prev_stall = 1'b0;
    always @(negedge CLK) begin
        word_t cur;
        word_t exp;
        cur = '{sof: OUT_SOF, eof: OUT_EOF, data: OUT_DATA};
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(OUT_VALID), 32'd1);
                check("stall_hold", 32'(cur), 32'(prev_word));
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    check("stream_word", 32'(cur), 32'(exp));
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_word  = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d2;
        logic [26:0]  vld4;
        logic [13:0]  vld5;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset_outputs", {8'd0, OUT_VALID, OUT_SOF, OUT_EOF, BUSY, DROP_COUNT, 4'd0},
              32'd0);
        check("reset_data", 32'(OUT_DATA), 32'd0);
        @(posedge CLK);
        #1 RESET_n = 1'b1;
        tick();

        // T1: all channels, ramp data, latency of one cycle to SYNC
        OUT_READY = 1'b1;
        push_frame(16'h0000, 16'hFFFF, ramp(16'h1000), 16'h0000);
        strobe_cycle(ramp(16'h1000), 16'hFFFF);
        @(negedge CLK);
        check("latency_sync", {14'd0, OUT_VALID, OUT_SOF, OUT_DATA}, {14'd0, 1'b1, 1'b1, 16'hEB90});
        wait_drain(40, "t1_drain");
        check("t1_idle", {30'd0, OUT_VALID, BUSY}, 32'd0);

        // T3: random back-pressure
        OUT_READY = 1'b0;
        push_frame(16'h0001, 16'hFFFF, ramp(16'h1000), 16'h0001);
        strobe_cycle(ramp(16'h1000), 16'hFFFF);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            OUT_READY = 1'($urandom_range(0, 1));
            tick();
        end
        OUT_READY = 1'b1;
        wait_drain(40, "t3_drain");

        // No channels enabled: SYNC, CNT, CSUM == CNT
        push_frame(16'h0002, 16'h0000, ramp(16'h0000), 16'h0002);
        strobe_cycle(ramp(16'h0000), 16'h0000);
        wait_drain(20, "t_zero_drain");

        // T2: sparse enable, ch0 and ch15 only
        d2 = {16{16'hDEAD}};
        d2[0*16 +: 16]  = 16'hAAAA;
        d2[15*16 +: 16] = 16'h5555;
        push_frame(16'h0003, 16'h8001, d2, 16'hFFFC);
        strobe_cycle(d2, 16'h8001);
        wait_drain(20, "t2_drain");
        check("t2_idle", 32'(BUSY), 32'd0);

        // T6: reset in the middle of DATA
        mon_en = 1'b0;
        exp_q.delete();
        strobe_cycle(ramp(16'h1000), 16'hFFFF);
        tick();
        tick();
        @(negedge CLK);
        check("mid_data", 32'(OUT_DATA), 32'h1000);
        tick();
        RESET_n = 1'b0;
        @(negedge CLK);
        check("abort_outputs", {8'd0, OUT_VALID, OUT_SOF, OUT_EOF, BUSY, DROP_COUNT, 4'd0},
              32'd0);
        check("abort_data", 32'(OUT_DATA), 32'd0);
        tick();
        RESET_n = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        check("no_resume", {30'd0, OUT_VALID, BUSY}, 32'd0);
        mon_en = 1'b1;

        // T4: stalled output, strobe 1 active, strobe 2 pending, strobe 3 dropped
        OUT_READY = 1'b0;
        push_frame(16'h0000, 16'hFFFF, ramp(16'h1000), 16'h0000);
        push_frame(16'h0001, 16'h0421, ramp(16'h1000), 16'h100E);
        strobe_cycle(ramp(16'h1000), 16'hFFFF);
        strobe_cycle(ramp(16'h1000), 16'h0421);
        strobe_cycle(ramp(16'h7000), 16'hFFFF);
        @(negedge CLK);
        check("drop_count_1", 32'(DROP_COUNT), 32'd1);
        check("busy_stalled", 32'(BUSY), 32'd1);
        tick();
        OUT_READY = 1'b1;
        for (int i = 0; i < 27; i++) begin
            @(negedge CLK);
            vld4[i] = OUT_VALID;
            tick();
        end
        check("t4_back_to_back", 32'(vld4), 32'h01FF_FFFF);
        check("t4_drain", 32'(exp_q.size()), 32'd0);
        check("t4_drop_hold", 32'(DROP_COUNT), 32'd1);
        check("t4_idle", 32'(BUSY), 32'd0);

        // T5: counter wrap plus strobes coinciding with CSUM transfers
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        push_frame(16'hFFFF, 16'h0000, ramp(16'h0000), 16'hFFFF);
        push_frame(16'h0000, 16'h0000, ramp(16'h0000), 16'h0000);
        push_frame(16'h0001, 16'h0000, ramp(16'h0000), 16'h0001);
        push_frame(16'h0002, 16'h0000, ramp(16'h0000), 16'h0002);
        for (int i = 0; i < 14; i++) begin
            SAMPLE_VALID = (i == 0) || (i == 1) || (i == 3) || (i == 9);
            SAMPLE_DATA  = ramp(16'h4000);
            CH_ENABLE    = 16'h0000;
            @(negedge CLK);
            vld5[i] = OUT_VALID;
            tick();
        end
        SAMPLE_VALID = 1'b0;
        check("t5_valid_pattern", 32'(vld5), 32'h0000_1FFE);
        check("t5_drain", 32'(exp_q.size()), 32'd0);
        check("t5_no_drop", 32'(DROP_COUNT), 32'd1);

        // Drop counter saturation
        force dut.u_snap.drop_count = 16'hFFFF;
        tick();
        release dut.u_snap.drop_count;
        OUT_READY = 1'b0;
        mon_en = 1'b0;
        strobe_cycle(ramp(16'h0000), 16'hFFFF);
        strobe_cycle(ramp(16'h0000), 16'hFFFF);
        strobe_cycle(ramp(16'h0000), 16'hFFFF);
        strobe_cycle(ramp(16'h0000), 16'hFFFF);
        @(negedge CLK);
        check("drop_saturate", 32'(DROP_COUNT), 32'h0000_FFFF);
        check("busy_saturate", 32'(BUSY), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
